alu_rr_arbiter: RTL and testbench

//   Shares one combinational 8-bit ALU (A, B, ALU_Sel -> ALU_Out, CarryOut) among NUM_REQ requesters.

---
 rtl/alu_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one combinational ALU among NUM_REQ requesters.
// One transaction in flight: grant, let the ALU settle a cycle, then hold the tagged result.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_carry
);

  // state | meaning
  // IDLE  | scanning requesters from ptr; grant is combinational
  // EXEC  | operands registered, ALU output settling
  // RESP  | tagged result held on rsp_* until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt, id, win_idx;
  logic [ID_W:0]   scan_idx;
  logic            win_found, accept, capture, release_rsp;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ))
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign ptr_nxt = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready = NUM_REQ'(1) << win_idx;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      id        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else begin
      if (accept) begin
        ptr     <= ptr_nxt;
        id      <= win_idx;
        alu_a   <= req_a[int'(win_idx)*WIDTH +: WIDTH];
        alu_b   <= req_b[int'(win_idx)*WIDTH +: WIDTH];
        alu_sel <= req_sel[int'(win_idx)*SEL_W +: SEL_W];
      end
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_carry <= alu_carry;
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end
      if (release_rsp) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (grant queue with ready times).
module tb_alu_rr_arbiter;
  localparam int N = 4, W = 8, S = 4, IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*S-1:0] req_sel;
  logic [W-1:0]   alu_a, alu_b, alu_out, rsp_data;
  logic [S-1:0]   alu_sel;
  logic           alu_carry, rsp_valid, rsp_ready, rsp_carry;
  logic [IDW-1:0] rsp_id;

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  // Reference 8-bit ALU; carry is the carry out of A+B regardless of select.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [S-1:0] sel);
    logic [W:0]   sum;
    logic [W-1:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (sel)
      4'h0: r = sum[W-1:0];
      4'h1: r = a - b;
      4'h2: r = a * b;
      4'h3: r = (b == '0) ? '0 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[W-2:0], a[W-1]};
      4'h7: r = {a[0], a[W-1:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? W'(1) : W'(0);
      default: r = (a == b) ? W'(1) : W'(0);
    endcase
    return {sum[W], r};
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: transactions in flight with the cycle their response must appear.
  typedef struct {
    int           id;
    logic [W-1:0] a, b;
    logic [S-1:0] sel;
    int           ready_cyc;
  } txn_t;

  txn_t         inflight[$];
  int           m_ptr = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [S-1:0] m_sel = '0;
  int           cyc = 0;
  logic [N-1:0] granted_last = '0;
  int           grant_ids[$];
  int           grant_cycs[$];

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [W:0]   r;
    logic         exp_rsp;
    int           win, idx;
    txn_t         t;
    cyc++;
    if (!rst_n) begin
      inflight.delete();
      m_ptr = 0; m_a = '0; m_b = '0; m_sel = '0;
    end
    win = -1;
    if (inflight.size() == 0)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_sel);
    exp_rsp = (inflight.size() > 0) && (cyc >= inflight[0].ready_cyc);
    chk("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp) begin
      r = alu_fn(inflight[0].a, inflight[0].b, inflight[0].sel);
      chk("rsp_id", rsp_id, inflight[0].id);
      chk("rsp_data", rsp_data, r[W-1:0]);
      chk("rsp_carry", rsp_carry, r[W]);
    end
    granted_last = req_valid & req_ready;
    for (int k = 0; k < N; k++)
      if (req_ready[k]) begin
        grant_ids.push_back(k);
        grant_cycs.push_back(cyc);
      end
    if (rst_n) begin
      if (exp_rsp && rsp_ready) void'(inflight.pop_front());
      else if (win >= 0) begin
        t.id = win;
        t.a = req_a[win*W +: W];
        t.b = req_b[win*W +: W];
        t.sel = req_sel[win*S +: S];
        t.ready_cyc = cyc + 2;
        inflight.push_back(t);
        m_a = t.a; m_b = t.b; m_sel = t.sel;
        m_ptr = (win + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [S-1:0] s);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_sel[i*S +: S] = s;
  endtask

  // Leaves the caller at the negedge where requester i is granted (or budget expired).
  task automatic wait_grant(input int i, input string nm);
    int budget;
    budget = 20;
    @(negedge clk);
    while (!req_ready[i] && budget > 0) begin
      @(posedge clk);
      @(negedge clk);
      budget--;
    end
    chk(nm, req_ready[i], 1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W:0]   r;
    int           s0, budget;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester 2: 0x0A + 0x02
    set_req(2, 8'h0A, 8'h02, 4'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_exec_alu_a", alu_a, 8'h0A);
    chk("t1_exec_rsp_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 2);
    chk("t1_rsp_data", rsp_data, 8'h0C);
    chk("t1_rsp_carry", rsp_carry, 0);
    tick();

    // Carry out: 0xF6 + 0x0A from requester 0 (pointer now at 3, wraps to 0)
    set_req(0, 8'hF6, 8'h0A, 4'h0);
    @(negedge clk);
    chk("t3_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("t3_rsp_id", rsp_id, 0);
    chk("t3_rsp_data", rsp_data, 8'h00);
    chk("t3_rsp_carry", rsp_carry, 1);
    tick();

    // Reset during EXEC aborts the transaction and rewinds the pointer
    set_req(1, 8'h33, 8'h44, 4'h9);
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_ready", req_ready, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_b", alu_b, 0);
    chk("t5_alu_sel", alu_sel, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_rsp_data", rsp_data, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 0);
      tick();
    end

    // All four valid continuously: grants 0,1,2,3,0, three cycles apart
    for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), S'($urandom));
    rsp_ready = 1'b1;
    s0 = grant_ids.size();
    budget = 40;
    while (grant_ids.size() - s0 < 5 && budget > 0) begin
      tick();
      budget--;
    end
    req_valid = '0;
    chk("t2_grant_count", grant_ids.size() - s0, 5);
    if (grant_ids.size() - s0 >= 5) begin
      chk("t2_grant0", grant_ids[s0], 0);
      chk("t2_grant1", grant_ids[s0+1], 1);
      chk("t2_grant2", grant_ids[s0+2], 2);
      chk("t2_grant3", grant_ids[s0+3], 3);
      chk("t2_grant4", grant_ids[s0+4], 0);
      for (int k = 1; k < 5; k++)
        chk("t2_spacing", grant_cycs[s0+k] - grant_cycs[s0+k-1], 3);
    end
    repeat (3) tick();

    // Backpressure: hold the result 5 cycles while requester 0 waits
    rsp_ready = 1'b0;
    set_req(2, 8'h55, 8'h0F, 4'h8);
    set_req(0, 8'h12, 8'h34, 4'h0);
    @(negedge clk);
    chk("t4_ready", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_data", rsp_data, 8'h05);
      chk("t4_hold_id", rsp_id, 2);
      chk("t4_hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Select sweep from requester 1
    for (int s = 0; s < 16; s++) begin
      a = W'($urandom);
      b = W'($urandom);
      set_req(1, a, b, S'(s));
      wait_grant(1, "t6_grant");
      tick();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("t6_alu_sel", alu_sel, s);
      chk("t6_alu_a", alu_a, a);
      tick();
      @(negedge clk);
      r = alu_fn(a, b, S'(s));
      chk("t6_rsp_data", rsp_data, r[W-1:0]);
      tick();
    end

    // Random traffic with random backpressure
    repeat (600) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || granted_last[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 2) == 0)
            set_req(i, W'($urandom), W'($urandom), S'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
